// File: rtl/raster_pkg.sv
// Shared definitions for the tile rasteriser: scheduler state encoding and
// the helper that builds the mask used to snap a coordinate down to its tile origin.
package raster_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    EMIT   = 3'd3,
    FINISH = 3'd4
  } state_e;

  localparam int unsigned MASK_W = 32;

  // Clearing the low log2(tile_edge) bits aligns a coordinate to its tile origin.
  function automatic logic [MASK_W-1:0] tile_align_mask(input int unsigned tile_edge);
    return ~(tile_edge - 32'd1);
  endfunction

endpackage

// File: rtl/tile_walker.sv
// Raster-order stepping of the current tile origin inside the captured bounding box.
// Sums are one bit wider than the coordinates so a step past the top of the range ends the row/traversal.
module tile_walker #(
  parameter int COORD_W = 10,
  parameter int T       = 16
) (
  input  logic [COORD_W-1:0] cur_x_i,
  input  logic [COORD_W-1:0] cur_y_i,
  input  logic [COORD_W-1:0] min_x_i,
  input  logic [COORD_W-1:0] max_x_i,
  input  logic [COORD_W-1:0] max_y_i,
  output logic [COORD_W-1:0] next_x_o,
  output logic [COORD_W-1:0] next_y_o,
  output logic               last_o
);

  localparam int SW = COORD_W + 1;
  localparam logic [SW-1:0] STEP = SW'(T);

  logic [SW-1:0] step_x;
  logic [SW-1:0] step_y;

  always_comb begin
    step_x   = {1'b0, cur_x_i} + STEP;
    step_y   = {1'b0, cur_y_i} + STEP;
    next_x_o = cur_x_i;
    next_y_o = cur_y_i;
    last_o   = 1'b0;
    if (step_x <= {1'b0, max_x_i}) begin
      next_x_o = step_x[COORD_W-1:0];
    end else if (step_y <= {1'b0, max_y_i}) begin
      next_x_o = min_x_i;
      next_y_o = step_y[COORD_W-1:0];
    end else begin
      last_o = 1'b1;
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Walks the tiles covering a triangle bounding box, issues each to an external edge
// evaluator one at a time, and forwards covered tiles downstream in raster order.
module tile_scheduler
  import raster_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int T       = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] bbox_min_x,
  input  logic [COORD_W-1:0] bbox_min_y,
  input  logic [COORD_W-1:0] bbox_max_x,
  input  logic [COORD_W-1:0] bbox_max_y,
  output logic               busy,
  output logic               eval_valid,
  output logic [COORD_W-1:0] eval_tile_x,
  output logic [COORD_W-1:0] eval_tile_y,
  input  logic               eval_result_valid,
  input  logic               eval_tile_inside,
  output logic               tile_valid,
  input  logic               tile_ready,
  output logic [COORD_W-1:0] tile_x,
  output logic [COORD_W-1:0] tile_y,
  output logic               done,
  output logic               timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [COORD_W-1:0] ALIGN_MASK = COORD_W'(tile_align_mask(T));
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  state_e state_q, state_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d, max_y_q, max_y_d;
  logic [COORD_W-1:0] tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic               advance;
  logic [COORD_W-1:0] walk_x, walk_y;
  logic               walk_last;

  tile_walker #(
    .COORD_W(COORD_W),
    .T      (T)
  ) u_walker (
    .cur_x_i (cur_x_q),
    .cur_y_i (cur_y_q),
    .min_x_i (min_x_q),
    .max_x_i (max_x_q),
    .max_y_i (max_y_q),
    .next_x_o(walk_x),
    .next_y_o(walk_y),
    .last_o  (walk_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      min_x_q       <= '0;
      max_x_q       <= '0;
      max_y_q       <= '0;
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      min_x_q       <= min_x_d;
      max_x_q       <= max_x_d;
      max_y_q       <= max_y_d;
      tile_x_q      <= tile_x_d;
      tile_y_q      <= tile_y_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    min_x_d       = min_x_q;
    max_x_d       = max_x_q;
    max_y_d       = max_y_q;
    tile_x_d      = tile_x_q;
    tile_y_d      = tile_y_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    advance       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          min_x_d       = bbox_min_x & ALIGN_MASK;
          max_x_d       = bbox_max_x;
          max_y_d       = bbox_max_y;
          cur_x_d       = bbox_min_x & ALIGN_MASK;
          cur_y_d       = bbox_min_y & ALIGN_MASK;
          timeout_err_d = 1'b0;
          if ((bbox_min_x > bbox_max_x) || (bbox_min_y > bbox_max_y)) begin
            state_d = FINISH;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_ONE;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (eval_result_valid) begin
          if (eval_tile_inside) begin
            tile_x_d = cur_x_q;
            tile_y_d = cur_y_q;
            state_d  = EMIT;
          end else begin
            advance = 1'b1;
          end
        end else if (cnt_q >= CNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      EMIT: begin
        if (tile_ready) begin
          advance = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (walk_last) begin
        state_d = FINISH;
      end else begin
        cur_x_d = walk_x;
        cur_y_d = walk_y;
        state_d = ISSUE;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign eval_valid  = (state_q == ISSUE);
  assign tile_valid  = (state_q == EMIT);
  assign done        = (state_q == FINISH);
  assign eval_tile_x = cur_x_q;
  assign eval_tile_y = cur_y_q;
  assign tile_x      = tile_x_q;
  assign tile_y      = tile_y_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Randomised bench for tile_scheduler: an in-bench evaluator and downstream sink,
// checked against a raster-order tile list computed directly from the bounding box.
module tb_tile_scheduler;

  localparam int COORD_W = 10;
  localparam int T       = 16;
  localparam int TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [COORD_W-1:0] bbox_min_x = '0, bbox_min_y = '0, bbox_max_x = '0, bbox_max_y = '0;
  logic               busy, eval_valid, tile_valid, done, timeout_err;
  logic [COORD_W-1:0] eval_tile_x, eval_tile_y, tile_x, tile_y;
  logic               eval_result_valid, eval_tile_inside, tile_ready;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  int allX[$], allY[$], expIssueX[$], expIssueY[$], expEmitX[$], expEmitY[$];
  int planDelay[$], planInside[$];
  int issueSeen = 0, emitSeen = 0, respIdx = 0, lastIssueCycle = 0, heldCycles = 0;
  int expTimeout = 0;
  int readyMode = 0;
  bit chkEn = 1'b0, respEn = 1'b0;

  tile_scheduler #(
    .COORD_W(COORD_W),
    .T      (T),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .bbox_min_x       (bbox_min_x),
    .bbox_min_y       (bbox_min_y),
    .bbox_max_x       (bbox_max_x),
    .bbox_max_y       (bbox_max_y),
    .busy             (busy),
    .eval_valid       (eval_valid),
    .eval_tile_x      (eval_tile_x),
    .eval_tile_y      (eval_tile_y),
    .eval_result_valid(eval_result_valid),
    .eval_tile_inside (eval_tile_inside),
    .tile_valid       (tile_valid),
    .tile_ready       (tile_ready),
    .tile_x           (tile_x),
    .tile_y           (tile_y),
    .done             (done),
    .timeout_err      (timeout_err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Every tile whose origin lies in the aligned box, rows of increasing y, x inner.
  function automatic void buildModel(input int mnx, input int mny, input int mxx, input int mxy);
    allX.delete();
    allY.delete();
    if (mnx > mxx || mny > mxy) return;
    for (int y = (mny / T) * T; y <= mxy; y += T)
      for (int x = (mnx / T) * T; x <= mxx; x += T) begin
        allX.push_back(x);
        allY.push_back(y);
      end
  endfunction

  // delayMode 0 = random 1..TIMEOUT-1; insideMode 0 = all, 1 = alternating, 2 = random.
  function automatic void makePlan(input int delayMode, input int insideMode, input int neverAt);
    planDelay.delete();
    planInside.delete();
    for (int k = 0; k < 400; k++) begin
      if (k == neverAt) planDelay.push_back(0);
      else if (delayMode > 0) planDelay.push_back(delayMode);
      else planDelay.push_back(int'($urandom_range(1, TIMEOUT - 1)));
      if (insideMode == 0) planInside.push_back(1);
      else if (insideMode == 1) planInside.push_back((k % 2 == 0) ? 1 : 0);
      else planInside.push_back(int'($urandom_range(0, 1)));
    end
  endfunction

  task automatic applyStimulus(input int mnx, input int mny, input int mxx, input int mxy,
                               input int startLen);
    int startCycle;
    int doneCycle;
    int got;
    buildModel(mnx, mny, mxx, mxy);
    expIssueX.delete(); expIssueY.delete(); expEmitX.delete(); expEmitY.delete();
    expTimeout = 0;
    for (int k = 0; k < allX.size(); k++) begin
      expIssueX.push_back(allX[k]);
      expIssueY.push_back(allY[k]);
      if (planDelay[k] == 0) begin
        expTimeout = 1;
        break;
      end
      if (planInside[k] != 0) begin
        expEmitX.push_back(allX[k]);
        expEmitY.push_back(allY[k]);
      end
    end
    issueSeen = 0;
    emitSeen  = 0;
    respIdx   = 0;
    @(negedge clk);
    bbox_min_x = COORD_W'(mnx);
    bbox_min_y = COORD_W'(mny);
    bbox_max_x = COORD_W'(mxx);
    bbox_max_y = COORD_W'(mxy);
    start      = 1'b1;
    startCycle = cycle;
    got        = 0;
    doneCycle  = 0;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      if (c == startLen) start = 1'b0;
      if (done) begin
        got = 1;
        doneCycle = cycle;
        break;
      end
    end
    checkOutput("done_seen", got, 1);
    checkOutput("issue_count", issueSeen, expIssueX.size());
    checkOutput("emit_count", emitSeen, expEmitX.size());
    checkOutput("timeout_err_at_done", int'(timeout_err), expTimeout);
    if (expTimeout != 0) checkOutput("timeout_latency", doneCycle - lastIssueCycle, TIMEOUT);
    if (expIssueX.size() == 0) checkOutput("invalid_latency", doneCycle - startCycle, 1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("done_one_cycle", int'(done), 0);
    if (got == 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  // Evaluator: answers each issued tile after its planned delay; plan delay 0 never answers.
  initial begin
    int d;
    eval_result_valid = 1'b0;
    eval_tile_inside  = 1'b0;
    forever begin
      @(negedge clk);
      if (respEn) begin
        eval_result_valid = 1'b0;
        if (eval_valid) begin
          d = (respIdx < planDelay.size()) ? planDelay[respIdx] : 1;
          eval_tile_inside = (respIdx < planInside.size()) ? (planInside[respIdx] != 0) : 1'b0;
          respIdx++;
          if (d != 0) begin
            repeat (d) @(negedge clk);
            eval_result_valid = 1'b1;
          end
        end else if ((tile_valid || !busy) && $urandom_range(0, 3) == 0) begin
          eval_result_valid = 1'b1;
          eval_tile_inside  = 1'b1;
        end
      end
    end
  end

  // Downstream sink: always ready, random, or stalling each tile for ten cycles.
  initial begin
    int holdCnt;
    holdCnt = 0;
    tile_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (readyMode == 0) begin
        tile_ready = 1'b1;
      end else if (readyMode == 1) begin
        tile_ready = ($urandom_range(0, 1) != 0);
      end else if (tile_valid && holdCnt < 10) begin
        tile_ready = 1'b0;
        holdCnt++;
      end else begin
        tile_ready = tile_valid;
        if (!tile_valid) holdCnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chkEn) begin
        if (eval_valid) begin
          if (issueSeen < expIssueX.size()) begin
            checkOutput("issue_x", int'(eval_tile_x), expIssueX[issueSeen]);
            checkOutput("issue_y", int'(eval_tile_y), expIssueY[issueSeen]);
          end else begin
            checkOutput("issue_extra", issueSeen + 1, expIssueX.size());
          end
          issueSeen++;
          lastIssueCycle = cycle;
        end else if (busy && !tile_valid && !done && issueSeen > 0 &&
                     issueSeen <= expIssueX.size()) begin
          checkOutput("wait_hold_x", int'(eval_tile_x), expIssueX[issueSeen - 1]);
          checkOutput("wait_hold_y", int'(eval_tile_y), expIssueY[issueSeen - 1]);
        end
        if (tile_valid) begin
          checkOutput("emit_no_issue", int'(eval_valid), 0);
          if (emitSeen < expEmitX.size()) begin
            checkOutput("emit_x", int'(tile_x), expEmitX[emitSeen]);
            checkOutput("emit_y", int'(tile_y), expEmitY[emitSeen]);
          end else begin
            checkOutput("emit_extra", emitSeen + 1, expEmitX.size());
          end
          if (tile_ready) emitSeen++;
          else heldCycles++;
        end
      end
    end
  end

  initial begin
    int mnx, mny, mxx, mxy, never;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_eval_valid", int'(eval_valid), 0);
    checkOutput("rst_tile_valid", int'(tile_valid), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_timeout_err", int'(timeout_err), 0);
    checkOutput("rst_eval_tile_x", int'(eval_tile_x), 0);
    checkOutput("rst_tile_y", int'(tile_y), 0);
    rst    = 1'b0;
    chkEn  = 1'b1;
    respEn = 1'b1;

    makePlan(2, 0, -1);
    applyStimulus(0, 0, 31, 31, 1);
    checkOutput("model_full_count", expIssueX.size(), 4);
    checkOutput("model_full_x1", expIssueX[1], 16);
    checkOutput("model_full_y2", expIssueY[2], 16);
    checkOutput("model_full_emits", expEmitX.size(), 4);

    makePlan(2, 1, -1);
    applyStimulus(5, 3, 20, 10, 1);
    checkOutput("model_alt_count", expIssueX.size(), 2);
    checkOutput("model_alt_x1", expIssueX[1], 16);
    checkOutput("model_alt_emits", expEmitX.size(), 1);

    readyMode  = 2;
    heldCycles = 0;
    makePlan(3, 0, -1);
    applyStimulus(0, 0, 15, 15, 1);
    checkOutput("stall_held_cycles", heldCycles, 10);
    readyMode = 0;

    makePlan(2, 0, -1);
    applyStimulus(40, 0, 30, 10, 2);
    checkOutput("model_invalid_count", expIssueX.size(), 0);

    makePlan(2, 0, 0);
    applyStimulus(0, 0, 31, 31, 1);
    checkOutput("model_timeout_count", expIssueX.size(), 1);
    repeat (3) @(negedge clk);
    checkOutput("timeout_err_sticky", int'(timeout_err), 1);

    makePlan(0, 2, -1);
    applyStimulus(1000, 1000, 1023, 1023, 1);
    checkOutput("model_edge_count", expIssueX.size(), 4);
    checkOutput("model_edge_x3", expIssueX[3], 1008);
    checkOutput("model_edge_y0", expIssueY[0], 992);
    checkOutput("timeout_err_cleared", int'(timeout_err), 0);

    chkEn  = 1'b0;
    respEn = 1'b0;
    eval_result_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rst_mid_issue", int'(eval_valid), 1);
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_eval_valid", int'(eval_valid), 0);
    checkOutput("rst_mid_eval_x", int'(eval_tile_x), 0);
    checkOutput("rst_mid_eval_y", int'(eval_tile_y), 0);
    checkOutput("rst_mid_done", int'(done), 0);
    eval_result_valid = 1'b1;
    eval_tile_inside  = 1'b1;
    @(negedge clk);
    eval_result_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("late_result_done", int'(done), 0);
      checkOutput("late_result_busy", int'(busy), 0);
      checkOutput("late_result_tile_valid", int'(tile_valid), 0);
      @(negedge clk);
    end
    chkEn  = 1'b1;
    respEn = 1'b1;

    for (int it = 0; it < 25; it++) begin
      mnx = int'($urandom_range(0, 1023));
      mny = int'($urandom_range(0, 1023));
      mxx = mnx + int'($urandom_range(0, 90));
      mxy = mny + int'($urandom_range(0, 90));
      if (mxx > 1023) mxx = 1023;
      if (mxy > 1023) mxy = 1023;
      if ($urandom_range(0, 9) == 0 && mny > 0) mxy = mny - 1;
      never = -1;
      if ($urandom_range(0, 9) == 0) never = int'($urandom_range(0, 3));
      readyMode = int'($urandom_range(0, 1));
      makePlan(0, 2, never);
      applyStimulus(mnx, mny, mxx, mxy, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
